serial_frame_receiver: RTL and testbench

- Downstream consumer of the calculator's serial transmit stage.
- Samples DataOut on each rising edge of ClkTx while DOutValid is high.
- Reassembles the 32-bit concatenated result frame and decodes it into operand, result, selector and flag fields.
- Holds each frame in a one-deep output register with a valid/ack handshake toward the checker or host, and reports framing errors and overruns.

---
 rtl/serial_frame_receiver.sv | 112 +++++++++++
 tb/tb_serial_frame_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - serial frame deserializer with one-deep held output and valid/ack handshake
// Samples DataOut on ClkTx rising strobes, reassembles a WIDTH-bit frame MSB first and decodes its fields.
module serial_frame_receiver #(
    parameter int SIZE  = 1,
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClkTx,
    input  logic             DOutValid,
    input  logic [SIZE-1:0]  DataOut,
    input  logic             FrameAck,
    output logic             FrameValid,
    output logic [WIDTH-1:0] FrameOut,
    output logic [7:0]       OutA,
    output logic [7:0]       OutB,
    output logic [7:0]       OutRes,
    output logic [3:0]       OutSel,
    output logic [3:0]       OutFlag,
    output logic             FrameError,
    output logic             Overrun,
    output logic [7:0]       FrameCount
);
    localparam int BEATS = WIDTH / SIZE;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateType;

    stateType        state;
    logic            clkTxQ;
    logic            stb;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shiftNext;
    logic [WIDTH-1:0] firstBeat;
    logic [CW-1:0]   beatCnt;

    assign stb = ClkTx & ~clkTxQ;

    // A full-width lane has nothing to shift; the new beat is the whole frame.
    if (SIZE < WIDTH) begin : gShift
        assign shiftNext = {shreg[WIDTH-SIZE-1:0], DataOut};
        assign firstBeat = {{(WIDTH-SIZE){1'b0}}, DataOut};
    end else begin : gWhole
        assign shiftNext = DataOut;
        assign firstBeat = DataOut;
    end

    assign OutA    = FrameOut[31:24];
    assign OutB    = FrameOut[23:16];
    assign OutRes  = FrameOut[15:8];
    assign OutSel  = FrameOut[7:4];
    assign OutFlag = FrameOut[3:0];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            clkTxQ     <= 1'b0;
            shreg      <= '0;
            beatCnt    <= '0;
            FrameValid <= 1'b0;
            FrameOut   <= '0;
            FrameError <= 1'b0;
            Overrun    <= 1'b0;
            FrameCount <= 8'd0;
        end else begin
            clkTxQ     <= ClkTx;
            FrameError <= 1'b0;
            // A reload in DONE below takes precedence over this release.
            if (FrameAck && FrameValid) begin
                FrameValid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (stb && DOutValid) begin
                        shreg   <= firstBeat;
                        beatCnt <= CW'(1);
                        state   <= (BEATS == 1) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (stb) begin
                        if (DOutValid) begin
                            shreg   <= shiftNext;
                            beatCnt <= beatCnt + CW'(1);
                            if (beatCnt == CW'(BEATS - 1)) begin
                                state <= DONE;
                            end
                        end else begin
                            FrameError <= 1'b1;
                            shreg      <= '0;
                            beatCnt    <= '0;
                            state      <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (!FrameValid || FrameAck) begin
                        FrameOut   <= shreg;
                        FrameValid <= 1'b1;
                        FrameCount <= FrameCount + 8'd1;
                    end else begin
                        Overrun <= 1'b1;
                    end
                    shreg   <= '0;
                    beatCnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - scoreboard bench for serial_frame_receiver
// Stimulus pushes accepted frames into a queue; a monitor pops them when the DUT presents a new frame.
module tb_serial_frame_receiver;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ClkTx = 1'b0, DOutValid = 1'b0, FrameAck = 1'b0;
    logic [0:0]  DataOut = 1'b0;
    logic        FrameValid, FrameError, Overrun;
    logic [31:0] FrameOut;
    logic [7:0]  OutA, OutB, OutRes, FrameCount;
    logic [3:0]  OutSel, OutFlag;

    logic        ClkTx8 = 1'b0, DOutValid8 = 1'b0, FrameAck8 = 1'b0;
    logic [7:0]  DataOut8 = 8'd0;
    logic        FrameValid8, FrameError8, Overrun8;
    logic [31:0] FrameOut8;
    logic [7:0]  OutA8, OutB8, OutRes8, FrameCount8;
    logic [3:0]  OutSel8, OutFlag8;

    typedef struct { logic [31:0] frame; logic [7:0] cnt; } expType;
    expType expQ[$];

    int   checks = 0, errors = 0;
    int   expErrors = 0, errSeen = 0;
    logic held = 1'b0, overrunExp = 1'b0;
    logic [7:0] countExp = 8'd0, lastCount = 8'd0;

    always #5 Clk = ~Clk;

    serial_frame_receiver #(.SIZE(1), .WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .ClkTx(ClkTx), .DOutValid(DOutValid), .DataOut(DataOut),
        .FrameAck(FrameAck), .FrameValid(FrameValid), .FrameOut(FrameOut), .OutA(OutA), .OutB(OutB),
        .OutRes(OutRes), .OutSel(OutSel), .OutFlag(OutFlag), .FrameError(FrameError),
        .Overrun(Overrun), .FrameCount(FrameCount)
    );

    serial_frame_receiver #(.SIZE(8), .WIDTH(32)) dut8 (
        .Clk(Clk), .Reset(Reset), .ClkTx(ClkTx8), .DOutValid(DOutValid8), .DataOut(DataOut8),
        .FrameAck(FrameAck8), .FrameValid(FrameValid8), .FrameOut(FrameOut8), .OutA(OutA8), .OutB(OutB8),
        .OutRes(OutRes8), .OutSel(OutSel8), .OutFlag(OutFlag8), .FrameError(FrameError8),
        .Overrun(Overrun8), .FrameCount(FrameCount8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            lastCount = 8'd0;
        end else if (FrameValid && FrameCount != lastCount) begin
            if (expQ.size() == 0) begin
                check("unexpected_frame", {24'd0, FrameCount}, {24'd0, lastCount});
            end else begin
                expType e;
                e = expQ.pop_front();
                check("mon_frame", FrameOut, e.frame);
                check("mon_fields", {OutA, OutB, OutRes, OutSel, OutFlag}, e.frame);
                check("mon_count", {24'd0, FrameCount}, {24'd0, e.cnt});
            end
            lastCount = FrameCount;
        end
        if (FrameError) errSeen++;
    end

    task automatic strobe(input logic v, input logic d, input logic ack);
        @(negedge Clk);
        ClkTx = 1'b1; DOutValid = v; DataOut = d;
        @(negedge Clk);
        ClkTx = 1'b0; FrameAck = ack;
        @(negedge Clk);
        FrameAck = 1'b0;
    endtask

    task automatic strobe8(input logic [7:0] d);
        @(negedge Clk);
        ClkTx8 = 1'b1; DOutValid8 = 1'b1; DataOut8 = d;
        @(negedge Clk);
        ClkTx8 = 1'b0;
        @(negedge Clk);
    endtask

    // nBeats < 32 aborts the frame after that many beats.
    task automatic sendFrame(input logic [31:0] v, input int nBeats, input logic ackDone);
        if (nBeats < 32) begin
            for (int i = 0; i < nBeats; i++) strobe(1'b1, v[31-i], 1'b0);
            strobe(1'b0, 1'b0, 1'b0);
            expErrors++;
        end else begin
            if (!held || ackDone) begin
                expQ.push_back('{v, countExp + 8'd1});
                countExp = countExp + 8'd1;
                held = 1'b1;
            end else begin
                overrunExp = 1'b1;
            end
            for (int i = 0; i < 32; i++) strobe(1'b1, v[31-i], (i == 31) && ackDone);
        end
        DOutValid = 1'b0;
        check("valid_after_frame", {31'd0, FrameValid}, {31'd0, held});
        check("overrun_after_frame", {31'd0, Overrun}, {31'd0, overrunExp});
        check("count_after_frame", {24'd0, FrameCount}, {24'd0, countExp});
    endtask

    task automatic ackFrame();
        @(negedge Clk);
        FrameAck = 1'b1;
        @(negedge Clk);
        FrameAck = 1'b0;
        held = 1'b0;
        check("valid_after_ack", {31'd0, FrameValid}, 32'd0);
        check("count_after_ack", {24'd0, FrameCount}, {24'd0, countExp});
    endtask

    task automatic pulseReset();
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, FrameValid}, 32'd0);
        check("rst_frame", FrameOut, 32'd0);
        check("rst_fields", {OutA, OutB, OutRes, OutSel, OutFlag}, 32'd0);
        check("rst_count", {24'd0, FrameCount}, 32'd0);
        check("rst_overrun", {31'd0, Overrun}, 32'd0);
        check("rst_error", {31'd0, FrameError}, 32'd0);
        ClkTx = 1'b0; DOutValid = 1'b0; FrameAck = 1'b0;
        held = 1'b0; overrunExp = 1'b0; countExp = 8'd0;
        expQ.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        #3 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_valid", {31'd0, FrameValid}, 32'd0);
        check("reset_count", {24'd0, FrameCount}, 32'd0);
        check("reset_overrun", {31'd0, Overrun}, 32'd0);
        Reset = 1'b1;

        sendFrame(32'h1234_4638, 32, 1'b0);
        check("single_a", {24'd0, OutA}, 32'h12);
        check("single_b", {24'd0, OutB}, 32'h34);
        check("single_res", {24'd0, OutRes}, 32'h46);
        check("single_sel_flag", {24'd0, OutSel, OutFlag}, 32'h38);
        ackFrame();

        sendFrame(32'hFFFF_FFFF, 9, 1'b0);
        check("abort_error_pulses", errSeen, expErrors);
        sendFrame(32'h0000_00FF, 32, 1'b0);
        sendFrame(32'hA5A5_0F0F, 32, 1'b0);
        check("overrun_holds_first", FrameOut, 32'h0000_00FF);
        sendFrame(32'h0BAD_CAFE, 32, 1'b1);
        check("ack_in_done_reload", FrameOut, 32'h0BAD_CAFE);

        strobe8(8'hDE); strobe8(8'hAD); strobe8(8'hBE);
        check("size8_not_yet", {31'd0, FrameValid8}, 32'd0);
        strobe8(8'hEF);
        DOutValid8 = 1'b0;
        check("size8_valid", {31'd0, FrameValid8}, 32'd1);
        check("size8_frame", FrameOut8, 32'hDEAD_BEEF);
        check("size8_count", {24'd0, FrameCount8}, 32'd1);
        check("size8_flags", {30'd0, FrameError8, Overrun8}, 32'd0);

        for (int i = 0; i < 16; i++) strobe(1'b1, 1'b1, 1'b0);
        pulseReset();
        check("reset_error_pulses", errSeen, expErrors);
        sendFrame(32'h1357_9BDF, 32, 1'b0);
        ackFrame();

        pulseReset();
        for (int n = 0; n < 256; n++) begin
            sendFrame($urandom, 32, 1'b0);
            ackFrame();
        end
        check("wrap_count", {24'd0, FrameCount}, 32'd0);
        check("wrap_overrun", {31'd0, Overrun}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) sendFrame($urandom, $urandom_range(1, 31), 1'b0);
            else sendFrame($urandom, 32, r == 2);
            if ($urandom_range(0, 2) != 0) ackFrame();
        end

        repeat (4) @(negedge Clk);
        check("queue_drained", expQ.size(), 32'd0);
        check("error_pulse_total", errSeen, expErrors);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
